// File: rtl/cdc_bus_dst.sv
// Destination endpoint of a req/ack toggle-handshake bus crossing.
// Synchronises req_tgl, captures src_data once per request edge, offers it via valid/ready and returns ack_tgl.
module cdc_bus_dst #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 4
) (
  input  logic             dst_clk,
  input  logic             dst_rst_n,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] src_data,
  output logic             ack_tgl,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic             proto_err
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_bus_dst: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_sync_s;
  logic                   req_seen_r;
  logic                   ack_r;
  logic                   valid_r;
  logic                   err_r;
  logic [WIDTH-1:0]       data_r;
  state_t                 state_r;

  // Multi-flop synchroniser for the request toggle; src_data is never synchronised.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_tgl};
    end
  end

  assign req_sync_s = sync_r[SYNC_STAGES-1];

  // Handshake FSM: capture on a new request edge, hold until the consumer accepts, then ack.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state_r    <= ST_IDLE;
      req_seen_r <= 1'b0;
      ack_r      <= 1'b0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      data_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_sync_s != req_seen_r) begin
            data_r     <= src_data;
            req_seen_r <= req_sync_s;
            valid_r    <= 1'b1;
            state_r    <= ST_HOLD;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // A further request edge before the ack is a sender violation; it stays pending, not captured.
          if (req_sync_s != req_seen_r) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
          if (dst_ready) begin
            valid_r <= 1'b0;
            ack_r   <= ~ack_r;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ack_tgl   = ack_r;
  assign dst_data  = data_r;
  assign dst_valid = valid_r;
  assign proto_err = err_r;

endmodule

// File: doc/cdc_bus_dst.md
Name: cdc_bus_dst

Overview:
- Destination-side endpoint of a req/ack toggle-handshake bus crossing. Runs entirely in the destination clock domain.
- A source-domain sender holds `src_data` stable, toggles `req_tgl`, and waits for `ack_tgl` to toggle back. The sender resynchronises `ack_tgl` with `cdc_bits`.
- This block synchronises `req_tgl` internally and captures the bus once per request edge. It presents the word to a local consumer with valid/ready and returns the acknowledge toggle.
- Companion to `cdc_bits` for multi-bit bus signals, which must not be bit-synchronised independently.

Parameters:
- WIDTH, 32, data bus width in bits.
- SYNC_STAGES, 4, flop stages on the `req_tgl` synchroniser. Minimum 2; values below 2 are an elaboration error.

Ports:
- dst_clk  input  1  destination clock; every flop in the block is on its rising edge.
- dst_rst_n  input  1  asynchronous, active-low reset.
- req_tgl  input  1  request toggle from the source domain; asynchronous to `dst_clk`.
- src_data  input  WIDTH  source-domain bus; held stable by the sender from before a `req_tgl` edge until the matching `ack_tgl` edge.
- ack_tgl  output  1  acknowledge toggle, driven directly from a flop.
- dst_data  output  WIDTH  captured word.
- dst_valid  output  1  `dst_data` holds an unconsumed word.
- dst_ready  input  1  consumer accepts the word.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous assert, synchronous to `dst_clk` on release): synchroniser chain=0, `req_seen`=0, `ack_tgl`=0, `dst_valid`=0, `dst_data`=0, `proto_err`=0, state=IDLE.
- Synchroniser: `req_tgl` feeds SYNC_STAGES flops; the last stage is `req_sync`. `req_sync` reflects a `req_tgl` change after SYNC_STAGES `dst_clk` edges.
- `src_data` is never synchronised. It is sampled only on an edge where the FSM captures, which is legal because the sender holds it stable.
- FSM, two states:
  - IDLE:
    - If `req_sync` != `req_seen`: `dst_data` <= `src_data`, `req_seen` <= `req_sync`, `dst_valid` <= 1, go HOLD.
    - Otherwise hold all state.
  - HOLD:
    - If `dst_ready`=1: `dst_valid` <= 0, `ack_tgl` <= ~`ack_tgl`, go IDLE.
    - `dst_data` is held unchanged while in HOLD.
    - If `req_sync` != `req_seen` on any HOLD edge (the sender toggled again before the ack): `proto_err` <= 1.
- Capture and error precedence:
  - The violating edge is not captured.
  - On return to IDLE, a still-differing `req_sync` is captured as a normal new request.
  - A double toggle that nets to no change is lost silently beyond `proto_err`.
- `proto_err` is cleared only by reset.
- Latency:
  - `req_tgl` toggle to `dst_valid`=1: SYNC_STAGES+1 edges.
  - `dst_valid`&`dst_ready` sampled to `ack_tgl` toggle: same edge, one-edge registered output.
- Throughput:
  - At most one word in flight. The next request is seen no earlier than the edge after `ack_tgl` toggles.
  - IDLE->HOLD can occur on the edge immediately after HOLD->IDLE if a new edge is already synchronised.
- `dst_valid` drops only on an accepted handshake. `dst_ready` is ignored in IDLE.
- Reset mid-operation:
  - An in-flight word is discarded and no ack is sent.
  - Both ends must be reset together. If the source holds `req_tgl`=1 across a destination-only reset, one capture occurs SYNC_STAGES+1 edges after release; this is required behaviour, not an error.
- No combinational path from any input to any output.

Test Plan:
1. Single transfer: SYNC_STAGES=4, `dst_ready`=1. Set `src_data`=0xDEADBEEF, toggle `req_tgl` 0->1 -> `dst_valid`=1 with `dst_data`=0xDEADBEEF exactly 5 edges later, for exactly 1 cycle; `ack_tgl` 0->1 on the accepting edge; `proto_err`=0.
2. Backpressure: hold `dst_ready`=0 for 10 cycles after `dst_valid` rises, changing `src_data` to 0x12345678 meanwhile -> `dst_data` stays 0xDEADBEEF, `dst_valid` stays 1, `ack_tgl` unchanged. Raise `dst_ready` -> one accept, `ack_tgl` toggles.
3. Back-to-back: a source model toggles `req_tgl` 4 further times, each after seeing the synchronised ack, with data 1,2,3,4 -> consumer receives 1,2,3,4 in order; `ack_tgl` ends at its initial value ^ 4 toggles.
4. Protocol violation: hold `dst_ready`=0 and toggle `req_tgl` a second time while in HOLD -> `proto_err`=1 within SYNC_STAGES+1 edges. Raise `dst_ready` -> first word accepted, pending edge captured as the next word; `proto_err` remains 1 until reset.
5. Reset mid-HOLD: assert `dst_rst_n`=0 while `dst_valid`=1 -> `dst_valid`, `ack_tgl`, `dst_data`, `proto_err` all 0 immediately, without waiting for a clock edge. Release with `req_tgl`=0 -> no spurious capture over 20 cycles.
6. SYNC_STAGES=2 build: repeat scenario 1 -> `dst_valid` rises 3 edges after the `req_tgl` toggle.
